radiant_trig_header_gen: RTL and testbench
==========================================

Name: radiant_trig_header_gen

Overview:
Trigger-time header capture stage, directly downstream of the trigger overlord in the sys_clk_i domain. On every live (trig_i) or dead (deadtrig_i) trigger it snapshots:
- event number
- 48-bit timestamp
- PPS count
- cycles-since-PPS
- trigger type

Each snapshot is queued in a small header FIFO and streamed out as a 4-word packet over a valid/ready interface to the event builder. Every trigger, including those taken during a dead period, yields exactly one header unless the FIFO overflows.

Parameters:
FIFO_DEPTH, 4, number of queued headers; power of 2, minimum 2.
TS_BITS, 48, timestamp counter width; fixed at 48 for the word map.

Ports:
sys_clk_i  input  1  system clock; sole clock.
rst_i  input  1  reset, synchronous, active-high.
pps_i  input  1  single-cycle PPS flag, sys_clk_i domain.
trig_i  input  1  single-cycle live trigger from overlord.
deadtrig_i  input  1  single-cycle trigger that occurred while dead.
trig_type_i  input  3  trigger source bits {pps, ext, int}, sampled with trig_i/deadtrig_i.
clear_i  input  1  run-start clear of event number, PPS count, drop count.
hdr_dat_o  output  32  header word.
hdr_valid_o  output  1  hdr_dat_o valid.
hdr_last_o  output  1  marks word 3 of a packet.
hdr_ready_i  input  1  consumer accepts the word when valid and ready are both high.
fifo_count_o  output  clog2(FIFO_DEPTH)+1  headers queued, including the one being streamed.
dropped_o  output  16  triggers lost to overflow; saturates at 16'hFFFF.

Behaviour:
Interface: one clock, sys_clk_i; reset rst_i is synchronous and active-high. Reset clears all counters, the FIFO and the output stage; every output reads 0 during and after reset.

Counters (update every cycle):
- timestamp: +1 every cycle; wraps modulo 2^48; not affected by clear_i.
- since_pps (32b): set to 0 on pps_i, else +1; saturates at 32'hFFFFFFFF.
- pps_count (16b): +1 on pps_i; wraps.
- evnum (24b): +1 on each trigger event, whether captured or dropped, so gaps reveal drops; wraps.

Trigger event and capture:
- A trigger event is trig_i | deadtrig_i. If both are high in the same cycle, it is one event with dead = 0.
- A capture uses register values as they stand in the trigger cycle, before that cycle's increments. A coincident pps_i is therefore not reflected in the captured values.

clear_i:
- Next cycle, evnum, pps_count and dropped_o are 0.
- Clear has priority over increments.
- A trigger in the same cycle as clear_i is captured with the pre-clear values.

FIFO:
- A trigger event while the FIFO holds FIFO_DEPTH entries is dropped and dropped_o increments.
- A slot freed in the same cycle (last word accepted) does not count as space. Full is evaluated before the pop.
- Entry written at trigger cycle N is visible in fifo_count_o at N+1.

Packet word map:
- W0 = {4'hA, dead, trig_type[2:0], evnum[23:0]}
- W1 = timestamp[31:0]
- W2 = {pps_count[15:0], timestamp[47:32]}
- W3 = since_pps[31:0]

Output FSM, states IDLE, W0, W1, W2, W3:
- IDLE -> W0 when the FIFO is non-empty. Best case, hdr_valid_o rises at N+2 for a trigger at N.
- Wk -> Wk+1 on hdr_valid_o & hdr_ready_i.
- W3 accept pops the entry, then goes to W0 if the FIFO is still non-empty, else IDLE. This gives back-to-back packets with no bubble.
- hdr_last_o is high only in W3.
- hdr_valid_o is high in W0..W3.
- hdr_dat_o is stable while valid && !ready; valid is never dropped without acceptance.
- Words are muxed from the FIFO head; no copy is made.

Reset mid-packet: the FSM returns to IDLE, the FIFO empties and the partial packet is abandoned. No recovery.

Test Plan:
1. Reset, then advance 100 cycles with pps_i at cycle 10; trig_i with type 3'b001 at cycle 50, ready held high. Expect one packet:
   - W0 = 32'hA100_0000
   - W1 = 50
   - W2 = 32'h0001_0000
   - W3 = 39
   - hdr_last_o on W3 only.
2. Five triggers 1 cycle apart with ready low, FIFO_DEPTH = 4. Then:
   - fifo_count_o = 4, dropped_o = 1.
   - Raise ready: four packets come out back-to-back with evnum 0,1,2,3 (event 4 dropped).
   - The next trigger carries evnum 5.
3. deadtrig_i and trig_i in the same cycle -> one packet with dead = 0. deadtrig_i alone -> W0 bit 27 = 1.
4. Random hdr_ready_i toggling across 50 packets -> hdr_dat_o is held stable while stalled, no word is lost or duplicated, and each packet is exactly 4 words.
5. pps_i coincident with trig_i -> captured pps_count and since_pps are the pre-PPS values. clear_i coincident with trig_i -> that packet carries the old evnum and the next trigger carries evnum 0.
6. Preload timestamp near 2^48-1 (force), trigger across the wrap -> W2 low half = 16'h0000 and W1 is small. Assert rst_i mid-W1 -> hdr_valid_o = 0 the next cycle and fifo_count_o = 0.

Source files
------------

// File: rtl/radiant_trig_header_gen.sv
// Trigger-time header capture: snapshots event number, timestamp and PPS
// counters on every trigger and streams each snapshot as a 4-word packet.
module radiant_trig_header_gen #(
  parameter int FIFO_DEPTH = 4,
  parameter int TS_BITS    = 48
) (
  input  logic                          sys_clk_i,
  input  logic                          rst_i,
  input  logic                          pps_i,
  input  logic                          trig_i,
  input  logic                          deadtrig_i,
  input  logic [2:0]                    trig_type_i,
  input  logic                          clear_i,
  output logic [31:0]                   hdr_dat_o,
  output logic                          hdr_valid_o,
  output logic                          hdr_last_o,
  input  logic                          hdr_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic [15:0]                   dropped_o
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;

  typedef struct packed {
    logic               dead;
    logic [2:0]         trigType;
    logic [23:0]        evnum;
    logic [TS_BITS-1:0] ts;
    logic [15:0]        ppsCount;
    logic [31:0]        sincePps;
  } hdr_t;

  typedef enum logic [2:0] {IDLE, W0, W1, W2, W3} state_t;

  logic [TS_BITS-1:0] timestamp_q;
  logic [31:0]        sincePps_q;
  logic [15:0]        ppsCount_q;
  logic [23:0]        evnum_q;
  logic [15:0]        dropped_q;

  hdr_t               mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0]   count_q, count_d;

  state_t             state_q;
  logic               valid_q, last_q;

  logic               trigEvent, full, push, accept, pop;
  hdr_t               snap, head;

  // Full is judged on the pre-pop occupancy, so a slot freed this cycle
  // cannot absorb a trigger arriving in the same cycle.
  always_comb begin
    trigEvent = trig_i | deadtrig_i;
    full      = (count_q == CNT_W'(FIFO_DEPTH));
    push      = trigEvent & ~full;
    accept    = valid_q & hdr_ready_i;
    pop       = accept & (state_q == W3);
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    head      = mem_q[rdPtr_q];
    snap      = '{dead:     deadtrig_i & ~trig_i,
                  trigType: trig_type_i,
                  evnum:    evnum_q,
                  ts:       timestamp_q,
                  ppsCount: ppsCount_q,
                  sincePps: sincePps_q};
  end

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      timestamp_q <= '0;
      sincePps_q  <= '0;
      ppsCount_q  <= '0;
      evnum_q     <= '0;
      dropped_q   <= '0;
    end else begin
      timestamp_q <= timestamp_q + TS_BITS'(1);
      if (pps_i)
        sincePps_q <= '0;
      else if (sincePps_q != '1)
        sincePps_q <= sincePps_q + 32'd1;

      if (clear_i)
        ppsCount_q <= '0;
      else if (pps_i)
        ppsCount_q <= ppsCount_q + 16'd1;

      if (clear_i)
        evnum_q <= '0;
      else if (trigEvent)
        evnum_q <= evnum_q + 24'd1;

      if (clear_i)
        dropped_q <= '0;
      else if (trigEvent && full && dropped_q != '1)
        dropped_q <= dropped_q + 16'd1;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (push)
      mem_q[wrPtr_q] <= snap;
  end

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push)
        wrPtr_q <= wrPtr_q + AW'(1);
      if (pop)
        rdPtr_q <= rdPtr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Leaving W3 looks at the post-pop occupancy so queued packets follow
  // each other without an idle cycle.
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (count_q != '0) begin
            state_q <= W0;
            valid_q <= 1'b1;
            last_q  <= 1'b0;
          end
        end
        W0: if (accept) state_q <= W1;
        W1: if (accept) state_q <= W2;
        W2: begin
          if (accept) begin
            state_q <= W3;
            last_q  <= 1'b1;
          end
        end
        W3: begin
          if (accept) begin
            last_q <= 1'b0;
            if (count_d != '0) begin
              state_q <= W0;
              valid_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    hdr_dat_o = '0;
    case (state_q)
      W0:      hdr_dat_o = {4'hA, head.dead, head.trigType, head.evnum};
      W1:      hdr_dat_o = head.ts[31:0];
      W2:      hdr_dat_o = {head.ppsCount, head.ts[TS_BITS-1:32]};
      W3:      hdr_dat_o = head.sincePps;
      default: hdr_dat_o = '0;
    endcase
  end

  assign hdr_valid_o  = valid_q;
  assign hdr_last_o   = last_q;
  assign fifo_count_o = count_q;
  assign dropped_o    = dropped_q;

endmodule

// File: tb/tb_radiant_trig_header_gen.sv
// Bench for radiant_trig_header_gen: queue-based reference model checked every
// cycle, plus directed scenarios pinned with hand-computed header words.
module tb_radiant_trig_header_gen;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, pps, trig, dead, clr, ready;
  logic [2:0]  ttype;
  logic [31:0] dat;
  logic        valid, last;
  logic [2:0]  cnt;
  logic [15:0] dropped;

  always #5 clk = ~clk;

  radiant_trig_header_gen #(.FIFO_DEPTH(DEPTH), .TS_BITS(48)) dut (
    .sys_clk_i    (clk),
    .rst_i        (rst),
    .pps_i        (pps),
    .trig_i       (trig),
    .deadtrig_i   (dead),
    .trig_type_i  (ttype),
    .clear_i      (clr),
    .hdr_dat_o    (dat),
    .hdr_valid_o  (valid),
    .hdr_last_o   (last),
    .hdr_ready_i  (ready),
    .fifo_count_o (cnt),
    .dropped_o    (dropped)
  );

  typedef struct {
    bit        dead;
    bit [2:0]  ttype;
    bit [23:0] ev;
    bit [47:0] ts;
    bit [15:0] pc;
    bit [31:0] sp;
  } hdr_t;

  // Reference model state
  hdr_t        mq[$];
  bit   [47:0] mTs;
  bit   [31:0] mSince;
  bit   [15:0] mPps, mDrop;
  bit   [23:0] mEv;
  bit          mEvt, mRstSeen, popPending, prevStall;
  logic [31:0] prevDat;
  int          wIdx = 0;
  int          cycle = 0;
  bit   [47:0] preloadVal;
  int          preloadSeq = 0, preloadSeen = 0;

  logic [31:0] logW[$];
  int          logC[$];

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] wordOf(hdr_t h, int k);
    case (k)
      0:       return {4'hA, h.dead, h.ttype, h.ev};
      1:       return h.ts[31:0];
      2:       return {h.pc, h.ts[47:32]};
      default: return h.sp;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Model advances on each rising edge; outputs are compared on the falling edge.
  initial begin
    forever begin
      @(posedge clk);
      cycle++;
      if (preloadSeq != preloadSeen) begin
        preloadSeen = preloadSeq;
        mTs = preloadVal;
      end
      if (rst) begin
        mq.delete();
        mTs = 0; mSince = 0; mPps = 0; mEv = 0; mDrop = 0;
        wIdx = 0; popPending = 0; mRstSeen = 1;
      end else begin
        mRstSeen = 0;
        mEvt = trig | dead;
        if (mEvt) begin
          if (mq.size() < DEPTH)
            mq.push_back('{dead: dead && !trig, ttype: ttype, ev: mEv, ts: mTs, pc: mPps, sp: mSince});
          else if (mDrop != 16'hFFFF)
            mDrop++;
        end
        if (popPending) begin
          void'(mq.pop_front());
          popPending = 0;
        end
        mTs++;
        mSince = pps ? 32'd0 : ((mSince == 32'hFFFF_FFFF) ? mSince : mSince + 32'd1);
        if (clr) begin
          mPps = 0; mEv = 0; mDrop = 0;
        end else begin
          if (pps)  mPps++;
          if (mEvt) mEv++;
        end
      end

      @(negedge clk);
      if (mRstSeen) begin
        checkOutput("rst_valid", valid, 0);
        checkOutput("rst_last", last, 0);
        checkOutput("rst_dat", dat, 0);
        checkOutput("rst_count", cnt, 0);
        checkOutput("rst_dropped", dropped, 0);
        prevStall = 0;
      end else begin
        checkOutput("fifo_count", cnt, mq.size());
        checkOutput("dropped", dropped, mDrop);
        if (mq.size() == 0) checkOutput("idle_valid", valid, 0);
        if (prevStall) begin
          checkOutput("stall_valid", valid, 1);
          checkOutput("stall_dat", dat, prevDat);
        end
        if (!valid) checkOutput("last_idle", last, 0);
        if (valid && mq.size() > 0) begin
          checkOutput("word", dat, wordOf(mq[0], wIdx));
          checkOutput("last", last, (wIdx == 3));
          if (ready) begin
            logW.push_back(dat);
            logC.push_back(cycle);
            if (wIdx == 3) begin
              wIdx = 0;
              popPending = 1;
            end else begin
              wIdx++;
            end
          end
        end
        prevStall = valid && !ready;
        prevDat   = dat;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input bit t, input bit d, input bit [2:0] ty, input bit p, input bit c);
    trig = t; dead = d; ttype = ty; pps = p; clr = c;
    tick(1);
    trig = 0; dead = 0; ttype = 3'b000; pps = 0; clr = 0;
  endtask

  task automatic applyReset();
    rst = 1;
    tick(2);
    rst = 0;
  endtask

  task automatic waitWords(input int n, input int budget, input string name);
    int k = 0;
    while (logW.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    if (logW.size() < n) checkOutput({name, "_timeout"}, logW.size(), n);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] w;
    int base, d0, expWords, k;
    bit done;

    rst = 1; pps = 0; trig = 0; dead = 0; clr = 0; ready = 0; ttype = 3'b000;

    // Reset state and a single packet with a PPS at cycle 10, trigger at cycle 50
    applyReset();
    checkOutput("reset_valid", valid, 0);
    checkOutput("reset_count", cnt, 0);
    checkOutput("reset_dropped", dropped, 0);
    ready = 1;
    tick(10);
    applyStimulus(0, 0, 3'b000, 1, 0);
    tick(39);
    base = logW.size();
    applyStimulus(1, 0, 3'b001, 0, 0);
    checkOutput("t1_valid_n1", valid, 0);
    tick(1);
    checkOutput("t1_valid_n2", valid, 1);
    waitWords(base + 4, 20, "t1");
    if (logW.size() >= base + 4) begin
      checkOutput("t1_w0", logW[base],     32'hA100_0000);
      checkOutput("t1_w1", logW[base + 1], 32'd50);
      checkOutput("t1_w2", logW[base + 2], 32'h0001_0000);
      checkOutput("t1_w3", logW[base + 3], 32'd39);
    end

    // Overflow: five triggers with the consumer stalled
    applyReset();
    ready = 0;
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 3'b010, 0, 0);
    checkOutput("t2_count", cnt, 4);
    checkOutput("t2_dropped", dropped, 1);
    base = logW.size();
    ready = 1;
    waitWords(base + 16, 40, "t2");
    if (logW.size() >= base + 16) begin
      for (int p = 0; p < 4; p++) begin
        w = logW[base + 4 * p];
        checkOutput("t2_evnum", w[23:0], p);
      end
      checkOutput("t2_back_to_back", logC[base + 15] - logC[base], 15);
    end
    base = logW.size();
    applyStimulus(1, 0, 3'b010, 0, 0);
    waitWords(base + 4, 20, "t2b");
    if (logW.size() >= base + 4) begin
      w = logW[base];
      checkOutput("t2_next_evnum", w[23:0], 5);
    end

    // Live and dead triggers together, then dead alone
    applyReset();
    ready = 1;
    base = logW.size();
    applyStimulus(1, 1, 3'b100, 0, 0);
    waitWords(base + 4, 20, "t3a");
    if (logW.size() >= base + 4) checkOutput("t3_both_w0", logW[base], 32'hA400_0000);
    base = logW.size();
    applyStimulus(0, 1, 3'b010, 0, 0);
    waitWords(base + 4, 20, "t3b");
    if (logW.size() >= base + 4) begin
      w = logW[base];
      checkOutput("t3_dead_bit", w[27], 1);
      checkOutput("t3_dead_w0", w, 32'hAA00_0001);
    end

    // 50 packets under random back-pressure
    applyReset();
    base = logW.size();
    d0 = mDrop;
    done = 0;
    fork
      begin
        for (int i = 0; i < 50; i++) begin
          applyStimulus(1, 0, 3'(i % 8), (i % 7) == 0, 0);
          tick(9);
        end
        done = 1;
      end
      begin
        while (!done) begin
          ready = 1'($urandom_range(0, 1));
          tick(1);
        end
      end
    join
    ready = 1;
    expWords = 4 * (50 - int'(mDrop - d0));
    waitWords(base + expWords, 400, "t4");
    tick(10);
    checkOutput("t4_words", logW.size() - base, expWords);

    // Coincident PPS and clear
    applyReset();
    ready = 1;
    base = logW.size();
    tick(5);
    applyStimulus(0, 0, 3'b000, 1, 0);
    tick(14);
    applyStimulus(1, 0, 3'b001, 1, 0);
    waitWords(base + 4, 20, "t5a");
    if (logW.size() >= base + 4) begin
      checkOutput("t5_pps_w1", logW[base + 1], 32'd20);
      checkOutput("t5_pps_w2", logW[base + 2], 32'h0001_0000);
      checkOutput("t5_pps_w3", logW[base + 3], 32'd14);
    end
    base = logW.size();
    applyStimulus(1, 0, 3'b001, 0, 1);
    waitWords(base + 4, 20, "t5b");
    if (logW.size() >= base + 4) begin
      checkOutput("t5_clr_w0", logW[base], 32'hA100_0001);
      w = logW[base + 2];
      checkOutput("t5_clr_pps", w[31:16], 2);
    end
    base = logW.size();
    applyStimulus(1, 0, 3'b001, 0, 0);
    waitWords(base + 4, 20, "t5c");
    if (logW.size() >= base + 4) begin
      checkOutput("t5_after_clr_w0", logW[base], 32'hA100_0000);
      w = logW[base + 2];
      checkOutput("t5_after_clr_pps", w[31:16], 0);
    end

    // Timestamp wrap, then reset in the middle of a packet
    applyReset();
    ready = 1;
    preloadVal = 48'hFFFF_FFFF_FFFE;
    force dut.timestamp_q = 48'hFFFF_FFFF_FFFE;
    preloadSeq++;
    #1;
    release dut.timestamp_q;
    tick(3);
    base = logW.size();
    applyStimulus(1, 0, 3'b001, 0, 0);
    waitWords(base + 4, 20, "t6a");
    if (logW.size() >= base + 4) begin
      checkOutput("t6_wrap_w1", logW[base + 1], 32'd1);
      checkOutput("t6_wrap_w2", logW[base + 2], 32'h0000_0000);
    end
    ready = 0;
    applyStimulus(1, 0, 3'b001, 0, 0);
    k = 0;
    while (!valid && k < 10) begin
      tick(1);
      k++;
    end
    checkOutput("t6_valid_rise", valid, 1);
    ready = 1;
    tick(1);
    ready = 0;
    rst = 1;
    tick(1);
    checkOutput("t6_rst_valid", valid, 0);
    checkOutput("t6_rst_count", cnt, 0);
    tick(1);
    rst = 0;
    tick(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
